// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset sequencer: FETCH/DECODE/EXEC/MEM/WB, stalling on imem/dmem req/ready.
// Define CTRL_PERF_COUNTER_EN to add the cycle_count/retired_count performance counters.
module multicycle_controller #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        illegal,
    output logic [2:0]  state_check
`ifdef CTRL_PERF_COUNTER_EN
    ,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] retired_count
`endif
);
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_RST    = 3'd6;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [2:0] state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [4:0] rd;
    logic       illegal_q;
    logic       is_r, is_i, is_lw, is_sw, is_beq, legal;
    logic [2:0] alu_fn;
    logic       unused_bits;

    // rs1/rs2 and the rest of funct7 go straight to the datapath, not through here.
    assign unused_bits = ^{instruction[31], instruction[29:15]};

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:          legal = (funct3 != 3'b011) && (!funct7_b5 || funct3 == 3'b000);
            OP_I:          legal = (funct3 != 3'b011) && !(funct3 == 3'b101 && funct7_b5);
            OP_LW, OP_SW:  legal = (funct3 == 3'b010);
            OP_BEQ:        legal = (funct3 == 3'b000);
            default:       legal = 1'b0;
        endcase
    end

    // funct7[5] only means SUB on register-register ops; ADDI ignores it.
    always_comb begin
        alu_fn = 3'd0;
        case (funct3)
            3'b000:  alu_fn = (is_r && funct7_b5) ? 3'd1 : 3'd0;
            3'b001:  alu_fn = 3'd5;
            3'b010:  alu_fn = 3'd7;
            3'b100:  alu_fn = 3'd4;
            3'b101:  alu_fn = 3'd6;
            3'b110:  alu_fn = 3'd3;
            3'b111:  alu_fn = 3'd2;
            default: alu_fn = 3'd0;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 3'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        result_src = 2'd0;
        case (state)
            ST_FETCH: begin
                imem_req   = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                ir_write   = imem_ready;
                pc_write   = imem_ready;
            end
            ST_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            ST_EXEC: begin
                alu_src_a = 2'd2;
                if (is_r) begin
                    alu_op = alu_fn;
                end else if (is_i) begin
                    alu_op    = alu_fn;
                    alu_src_b = 2'd1;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 2'd1;
                end else if (is_beq) begin
                    alu_op   = 3'd1;
                    pc_write = zero;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
            end
            ST_WB: begin
                reg_write  = (rd != 5'd0);
                result_src = is_lw ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

    assign illegal     = illegal_q;
    assign state_check = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RST;
            illegal_q <= 1'b0;
            opcode    <= 7'd0;
            funct3    <= 3'd0;
            funct7_b5 <= 1'b0;
            rd        <= 5'd0;
        end else begin
            case (state)
                ST_RST: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ready) begin
                        opcode    <= instruction[6:0];
                        funct3    <= instruction[14:12];
                        funct7_b5 <= instruction[30];
                        rd        <= instruction[11:7];
                        state     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (legal) begin
                        state <= ST_EXEC;
                    end else begin
                        state     <= ST_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (is_lw || is_sw) state <= ST_MEM;
                    else if (is_beq)    state <= ST_FETCH;
                    else                state <= ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ready) state <= is_sw ? ST_FETCH : ST_WB;
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

`ifdef CTRL_PERF_COUNTER_EN
    logic retire;
    assign retire = (state == ST_WB)
                  || (state == ST_MEM && is_sw && dmem_ready)
                  || (state == ST_EXEC && is_beq);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (state != ST_RST && state != ST_HALT) cycle_count <= cycle_count + 1'b1;
            if (retire) retired_count <= retired_count + 1'b1;
        end
    end
`else
    logic [COUNT_WIDTH-1:0] unused_count;
    assign unused_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: builds the expected per-cycle control trace of each instruction and replays it.
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'd0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, zero = 1'b0;
    logic        imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write, illegal;
    logic [2:0]  alu_op, state_check;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
`ifdef CTRL_PERF_COUNTER_EN
    logic [31:0] cycle_count, retired_count;
`endif

    multicycle_controller #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .illegal(illegal), .state_check(state_check)
`ifdef CTRL_PERF_COUNTER_EN
        , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write;
        logic [2:0] op;
        logic [1:0] sa, sb, rs;
        logic       ill;
    } exp_t;

    typedef struct {
        logic        imr, dmr, z;
        logic [31:0] ins;
        exp_t        e;
        bit          ret;
    } cyc_t;

    cyc_t        trace[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned m_cycles = 0;
    int unsigned m_retired = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t e;
        e = {state_check, imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write,
             alu_op, alu_src_a, alu_src_b, result_src, illegal};
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic imr, input logic dmr, input logic z,
                                 input logic [31:0] ins, input exp_t e, input bit ret);
        cyc_t c;
        c.imr = imr; c.dmr = dmr; c.z = z; c.ins = ins; c.e = e; c.ret = ret;
        trace.push_back(c);
    endfunction

    function automatic bit is_legal(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: return f3 != 3'd3 && (ins[30] == 1'b0 || f3 == 3'd0);
            7'b0010011: return f3 != 3'd3 && !(f3 == 3'd5 && ins[30]);
            7'b0000011: return f3 == 3'd2;
            7'b0100011: return f3 == 3'd2;
            7'b1100011: return f3 == 3'd0;
            default:    return 1'b0;
        endcase
    endfunction

    // ALU code for an arithmetic funct3 (ADD/SUB/AND/OR/XOR/SLL/SRL/SLT = 0..7).
    function automatic logic [2:0] op_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 3'd1 : 3'd0;
            3'd1:    return 3'd5;
            3'd2:    return 3'd7;
            3'd4:    return 3'd4;
            3'd5:    return 3'd6;
            3'd6:    return 3'd3;
            default: return 3'd2;
        endcase
    endfunction

    // Expected trace of one instruction: fw fetch stalls, mw memory stalls, z on the branch.
    function automatic void build(input logic [31:0] ins, input int fw, input int mw,
                                  input logic z, input int halt_n);
        exp_t e;
        logic [6:0] opc;
        bit r_t, i_t, lw_t, sw_t, beq_t;
        opc = ins[6:0];
        r_t = opc == 7'b0110011; i_t = opc == 7'b0010011;
        lw_t = opc == 7'b0000011; sw_t = opc == 7'b0100011; beq_t = opc == 7'b1100011;
        for (int i = 0; i < fw; i++) begin
            e = mk(3'd0); e.imem_req = 1; e.sb = 2'd2; e.rs = 2'd2;
            push(1'b0, rb(), rb(), $urandom, e, 0);
        end
        e = mk(3'd0); e.imem_req = 1; e.sb = 2'd2; e.rs = 2'd2; e.ir_write = 1; e.pc_write = 1;
        push(1'b1, rb(), rb(), ins, e, 0);
        e = mk(3'd1); e.sa = 2'd1; e.sb = 2'd1;
        push(rb(), rb(), rb(), $urandom, e, 0);
        if (!is_legal(ins)) begin
            for (int i = 0; i < halt_n; i++) begin
                e = mk(3'd5); e.ill = 1;
                push(rb(), rb(), rb(), $urandom, e, 0);
            end
            return;
        end
        e = mk(3'd2); e.sa = 2'd2;
        if (r_t) e.op = op_of(ins[14:12], ins[30]);
        if (i_t) begin e.op = op_of(ins[14:12], 1'b0); e.sb = 2'd1; end
        if (lw_t || sw_t) e.sb = 2'd1;
        if (beq_t) begin e.op = 3'd1; e.pc_write = z; end
        push(rb(), rb(), beq_t ? z : rb(), $urandom, e, beq_t);
        if (beq_t) return;
        if (lw_t || sw_t) begin
            for (int i = 0; i < mw; i++) begin
                e = mk(3'd3); e.dmem_req = 1; e.dmem_we = sw_t;
                push(rb(), 1'b0, rb(), $urandom, e, 0);
            end
            e = mk(3'd3); e.dmem_req = 1; e.dmem_we = sw_t;
            push(rb(), 1'b1, rb(), $urandom, e, sw_t);
            if (sw_t) return;
        end
        e = mk(3'd4); e.reg_write = (ins[11:7] != 5'd0); e.rs = lw_t ? 2'd1 : 2'd0;
        push(rb(), rb(), rb(), $urandom, e, 1);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val(tag, 32'(observed()), 32'(mk(3'd6)));
`ifdef CTRL_PERF_COUNTER_EN
        check_val({tag, " cycles"}, cycle_count, 32'd0);
        check_val({tag, " retired"}, retired_count, 32'd0);
`endif
    endtask

    task automatic run(input bit abort_exec);
        cyc_t c;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            @(posedge clk); #1;
            imem_ready = c.imr; dmem_ready = c.dmr; zero = c.z; instruction = c.ins;
            #2;
            check_val($sformatf("ctl st%0d", c.e.st), 32'(observed()), 32'(c.e));
`ifdef CTRL_PERF_COUNTER_EN
            check_val("cycle_count", cycle_count, m_cycles);
            check_val("retired_count", retired_count, m_retired);
`endif
            if (c.e.st != 3'd5 && c.e.st != 3'd6) m_cycles++;
            if (c.ret) m_retired++;
            if (abort_exec && c.e.st == 3'd2) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("async reset in EXEC");
                trace.delete();
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset asserted");
        @(posedge clk); #1;
        reset = 1'b1;
        imem_ready = 1'b1; dmem_ready = 1'b1; zero = rb(); instruction = $urandom;
        #2;
        check_val("rst state after release", 32'(observed()), 32'(mk(3'd6)));
        m_cycles = 0;
        m_retired = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 6))
            0: begin ins[6:0] = 7'b0110011; if (rb()) ins[30] = 1'b0; end
            1: ins[6:0] = 7'b0010011;
            2: begin ins[6:0] = 7'b0000011; if (rb()) ins[14:12] = 3'd2; end
            3: begin ins[6:0] = 7'b0100011; if (rb()) ins[14:12] = 3'd2; end
            4: begin ins[6:0] = 7'b1100011; if (rb()) ins[14:12] = 3'd0; end
            5: ins[6:0] = 7'($urandom);
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        logic [31:0] ins;
        do_reset();
        build(32'h005303b3, 0, 0, 1'b0, 0); run(0);
        build(32'h005303b3, 3, 0, 1'b0, 0); run(0);
        build(32'h00000463, 0, 0, 1'b1, 0); run(0);
        build(32'h00000463, 1, 0, 1'b0, 0); run(0);
        build(32'h0002a303, 0, 2, 1'b0, 0); run(0);
        build(32'h0062a223, 0, 1, 1'b0, 0); run(0);
        build(32'h005303b3, 1, 0, 1'b0, 0); run(1);
        do_reset();
        build(32'h00000000, 0, 0, 1'b0, 12); run(0);
        do_reset();
        repeat (300) begin
            ins = rand_instr();
            build(ins, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 4);
            run(0);
            if (!is_legal(ins)) do_reset();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
